// File: rtl/lc3b_types.sv
// lc3b_types: shared bus, cache-state and geometry definitions
package lc3b_types;
  typedef logic [127:0] lc3b_datbus;
  typedef enum logic [1:0] {DC_CHECK, DC_WB, DC_ALLOC} lc3b_dcache_state_t;
  localparam int DC_OFFSET_BITS = 4;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/dirty/tag/data storage, combinational read, byte-masked synchronous write
module dcache_array
  import lc3b_types::*;
#(
  parameter int SET_BITS = 3,
  parameter int TAG_BITS = 16 - DC_OFFSET_BITS - SET_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SET_BITS-1:0] idx,
  input  logic [15:0]         mask,
  input  lc3b_datbus          wdata,
  input  logic                tag_we,
  input  logic [TAG_BITS-1:0] tag_in,
  input  logic                dirty_set,
  input  logic                dirty_clr,
  output logic                valid,
  output logic                dirty,
  output logic [TAG_BITS-1:0] tag,
  output lc3b_datbus          line
);
  localparam int SETS = 1 << SET_BITS;
  logic [SETS-1:0] valid_q, dirty_q;
  logic [TAG_BITS-1:0] tag_q [SETS];
  lc3b_datbus data_q [SETS];
  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag = tag_q[idx];
  assign line = data_q[idx];
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (tag_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (dirty_set) begin
      dirty_q[idx] <= 1'b1;
    end else if (dirty_clr) begin
      dirty_q[idx] <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++)
      if (mask[i]) data_q[idx][8*i +: 8] <= wdata[8*i +: 8];
    if (tag_we) tag_q[idx] <= tag_in;
  end
endmodule

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped write-back write-allocate L1 data cache
// Defining DCACHE_PERF_CNT_EN adds saturating hit/miss/writeback counters.
module l1_dcache
  import lc3b_types::*;
#(
  parameter int SET_BITS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  lc3b_datbus  mem_wdata,
  input  logic [15:0] mem_byte_en,
  output lc3b_datbus  mem_rdata,
  output logic        mem_resp,
  output logic [15:0] pmem_addr,
  output logic        pmem_read,
  output logic        pmem_write,
  output lc3b_datbus  pmem_wdata,
  input  lc3b_datbus  pmem_rdata,
  input  logic        pmem_resp
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses,
  output logic [31:0] perf_wbs
`endif
);
  localparam int TAG_BITS = 16 - DC_OFFSET_BITS - SET_BITS;
  lc3b_dcache_state_t state, state_n;
  logic [15-DC_OFFSET_BITS:0] line_addr, cur;
  logic [SET_BITS-1:0] idx;
  logic [TAG_BITS-1:0] atag, tag;
  logic valid, dirty, hit, tag_we, dirty_set, dirty_clr;
  logic [15:0] mask;
  lc3b_datbus line, wdata;
  logic unused;
  assign unused = &{1'b0, mem_addr[DC_OFFSET_BITS-1:0]};
  // The miss line is latched so a dropped request still completes its fill.
  assign cur = (state == DC_CHECK) ? mem_addr[15:DC_OFFSET_BITS] : line_addr;
  assign idx = cur[SET_BITS-1:0];
  assign atag = cur[15-DC_OFFSET_BITS -: TAG_BITS];
  assign hit = valid && tag == atag;
  assign mem_rdata = mem_resp ? line : '0;
  assign wdata = (state == DC_ALLOC) ? pmem_rdata : mem_wdata;
  dcache_array #(.SET_BITS(SET_BITS), .TAG_BITS(TAG_BITS)) u_array (
    .clk(clk), .reset(reset), .idx(idx), .mask(mask), .wdata(wdata),
    .tag_we(tag_we), .tag_in(atag), .dirty_set(dirty_set), .dirty_clr(dirty_clr),
    .valid(valid), .dirty(dirty), .tag(tag), .line(line)
  );
  always_ff @(posedge clk) begin
    if (reset) state <= DC_CHECK;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (state == DC_CHECK) line_addr <= mem_addr[15:DC_OFFSET_BITS];
  end
  // Every output and array write is gated by reset so a mid-miss reset drops requests at once.
  always_comb begin
    state_n = state;
    mem_resp = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_addr = '0;
    pmem_wdata = '0;
    mask = '0;
    tag_we = 1'b0;
    dirty_set = 1'b0;
    dirty_clr = 1'b0;
    if (!reset)
      case (state)
        DC_CHECK:
          if (mem_req && hit) begin
            mem_resp = 1'b1;
            mask = mem_we ? mem_byte_en : '0;
            dirty_set = mem_we && |mem_byte_en;
          end else if (mem_req) begin
            state_n = (valid && dirty) ? DC_WB : DC_ALLOC;
          end
        DC_WB: begin
          pmem_write = 1'b1;
          pmem_addr = {tag, idx, 4'h0};
          pmem_wdata = line;
          dirty_clr = pmem_resp;
          state_n = pmem_resp ? DC_ALLOC : DC_WB;
        end
        DC_ALLOC: begin
          pmem_read = 1'b1;
          pmem_addr = {cur, 4'h0};
          mask = pmem_resp ? '1 : '0;
          tag_we = pmem_resp;
          state_n = pmem_resp ? DC_CHECK : DC_ALLOC;
        end
        default: state_n = DC_CHECK;
      endcase
  end
`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_hits <= '0;
      perf_misses <= '0;
      perf_wbs <= '0;
    end else begin
      if (mem_resp && perf_hits != '1) perf_hits <= perf_hits + 32'd1;
      if (state == DC_CHECK && state_n != DC_CHECK && perf_misses != '1) perf_misses <= perf_misses + 32'd1;
      if (state == DC_WB && pmem_resp && perf_wbs != '1) perf_wbs <= perf_wbs + 32'd1;
    end
  end
`endif
endmodule
